myproject_hls_deadlock_reporter: RTL

MYPROJECT_HLS_DEADLOCK_REPORTER -- requirements
Module: myproject_hls_deadlock_reporter

---
 rtl/myproject_hls_deadlock_pkg.sv | 28 ++
 rtl/myproject_hls_deadlock_confirm_cnt.sv | 36 +++
 rtl/myproject_hls_deadlock_reporter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/myproject_hls_deadlock_pkg.sv
// Shared types and constants for the HLS deadlock reporter: FSM states, timestamp width and report field offsets.
package myproject_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLD    = 2'd3
    } dl_state_e;

    localparam int TIMESTAMP_W = 32;
    localparam int CNT_W       = 8;
    localparam int CHAN_LSB    = 0;

    // Report layout is {timestamp, axis_snap, chan_snap} with chan_snap at bit 0.
    function automatic int axis_lsb(input int num_proc);
        return num_proc;
    endfunction

    function automatic int ts_lsb(input int num_proc);
        return 2 * num_proc;
    endfunction

    function automatic int report_w(input int num_proc);
        return 2 * num_proc + TIMESTAMP_W;
    endfunction

endpackage

// File: rtl/myproject_hls_deadlock_confirm_cnt.sv
// Saturating 8-bit debounce counter; done flags the cycle that completes the confirm window.
module myproject_hls_deadlock_confirm_cnt
    import myproject_hls_deadlock_pkg::*;
#(
    parameter int unsigned CONFIRM_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] DONE_VAL = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Counter register: clear beats load beats increment; increment stops at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign done = (cnt == DONE_VAL);

endmodule

// File: rtl/myproject_hls_deadlock_reporter.sv
// Debounces the deadlock-monitor block signal, snapshots the blocked processes and offers one report.
// Optional macro DEADLOCK_REPORT_TIMESTAMP_EN builds the free-running timestamp; otherwise the field reads 0.
module myproject_hls_deadlock_reporter
    import myproject_hls_deadlock_pkg::*;
#(
    parameter int unsigned            NUM_PROC       = 6,
    parameter int unsigned            CONFIRM_CYCLES = 16,
    parameter logic [TIMESTAMP_W-1:0] TIMESTAMP_INIT = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         block,
    input  logic [NUM_PROC-1:0]          chan_block_vec,
    input  logic [NUM_PROC-1:0]          axis_block_vec,
    input  logic                         clear,
    output logic                         report_valid,
    input  logic                         report_ready,
    output logic [2*NUM_PROC+TIMESTAMP_W-1:0] report_data,
    output logic                         deadlock_flag
);

    localparam int  REPORT_W       = report_w(NUM_PROC);
    localparam int  AXIS_LSB       = axis_lsb(NUM_PROC);
    localparam int  TS_LSB         = ts_lsb(NUM_PROC);
    localparam bit  DIRECT_CAPTURE = (CONFIRM_CYCLES == 1);

    dl_state_e               state_r;
    dl_state_e               state_s;
    logic                    cnt_load_s;
    logic                    cnt_inc_s;
    logic                    cnt_clr_s;
    logic                    capture_s;
    logic                    handshake_s;
    logic [CNT_W-1:0]        confirm_cnt_s;
    logic                    cnt_done_s;
    logic [TIMESTAMP_W-1:0]  timestamp_s;
    logic [NUM_PROC-1:0]     chan_snap_r;
    logic [NUM_PROC-1:0]     axis_snap_r;
    logic [TIMESTAMP_W-1:0]  ts_snap_r;
    logic [REPORT_W-1:0]     snap_s;

    assign handshake_s = report_valid & report_ready;

`ifdef DEADLOCK_REPORT_TIMESTAMP_EN
    logic [TIMESTAMP_W-1:0] ts_r;

    // Free-running cycle counter; wraps silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= TIMESTAMP_INIT;
        end else begin
            ts_r <= ts_r + TIMESTAMP_W'(1);
        end
    end

    assign timestamp_s = ts_r;
`else
    logic unused_ts_init_s;
    assign unused_ts_init_s = ^TIMESTAMP_INIT;
    assign timestamp_s      = {TIMESTAMP_W{1'b0}};
`endif

    myproject_hls_deadlock_confirm_cnt #(
        .CONFIRM_CYCLES (CONFIRM_CYCLES)
    ) u_confirm_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load_s),
        .inc     (cnt_inc_s),
        .clr     (cnt_clr_s),
        .cnt     (confirm_cnt_s),
        .done    (cnt_done_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clear overrides everything, including a coincident handshake.
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (block) begin
                        state_s = DIRECT_CAPTURE ? ST_REPORT : ST_CONFIRM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CONFIRM: begin
                    if (!block) begin
                        state_s = ST_IDLE;
                    end else if (cnt_done_s) begin
                        state_s = ST_REPORT;
                    end else begin
                        state_s = ST_CONFIRM;
                    end
                end
                ST_REPORT: begin
                    if (handshake_s) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_REPORT;
                    end
                end
                ST_HOLD: state_s = ST_HOLD;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM control decode for the debounce counter and snapshot capture.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        cnt_clr_s  = clear;
        capture_s  = 1'b0;
        if (!clear) begin
            case (state_r)
                ST_IDLE: begin
                    if (block) begin
                        capture_s  = DIRECT_CAPTURE;
                        cnt_load_s = !DIRECT_CAPTURE;
                    end else begin
                        cnt_clr_s  = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (block && cnt_done_s) begin
                        capture_s = 1'b1;
                        cnt_clr_s = 1'b1;
                    end else if (block) begin
                        cnt_inc_s = 1'b1;
                    end else begin
                        cnt_clr_s = 1'b1;
                    end
                end
                ST_REPORT: cnt_clr_s = 1'b1;
                ST_HOLD:   cnt_clr_s = 1'b1;
                default:   cnt_clr_s = 1'b1;
            endcase
        end else begin
            cnt_clr_s = 1'b1;
        end
    end

    // Handshake valid and sticky flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            report_valid  <= 1'b0;
            deadlock_flag <= 1'b0;
        end else if (clear) begin
            report_valid  <= 1'b0;
            deadlock_flag <= 1'b0;
        end else if (capture_s) begin
            report_valid  <= 1'b1;
            deadlock_flag <= 1'b1;
        end else if (handshake_s) begin
            report_valid  <= 1'b0;
            deadlock_flag <= deadlock_flag;
        end else begin
            report_valid  <= report_valid;
            deadlock_flag <= deadlock_flag;
        end
    end

    // Snapshot registers change only at capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chan_snap_r <= {NUM_PROC{1'b0}};
            axis_snap_r <= {NUM_PROC{1'b0}};
            ts_snap_r   <= {TIMESTAMP_W{1'b0}};
        end else if (capture_s) begin
            chan_snap_r <= chan_block_vec;
            axis_snap_r <= axis_block_vec;
            ts_snap_r   <= timestamp_s;
        end else begin
            chan_snap_r <= chan_snap_r;
            axis_snap_r <= axis_snap_r;
            ts_snap_r   <= ts_snap_r;
        end
    end

    // Report word assembly; gated by valid so the bus reads zero when idle or in reset.
    always_comb begin
        snap_s = {REPORT_W{1'b0}};
        snap_s[CHAN_LSB +: NUM_PROC]    = chan_snap_r;
        snap_s[AXIS_LSB +: NUM_PROC]    = axis_snap_r;
        snap_s[TS_LSB   +: TIMESTAMP_W] = ts_snap_r;
    end

    assign report_data = snap_s & {REPORT_W{report_valid}};

endmodule
